// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the CPU memory interface.
// Holds MAR/MDR, runs one read or write per mio_en pulse through a
// mem_req/mem_ready handshake, and pulses r_done (LC-3 "R") for one cycle
// when the access finishes.
// Optional feature macro: MEM_TIMEOUT_EN. When defined, an access that waits
// TIMEOUT cycles is aborted, err is set, and an aborted read returns all ones.
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              r_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   we_q;
    logic   idle;
    logic   start;
    logic   complete;
    logic   abort;

    // Loads and starts are only honoured in IDLE; everything else is locked out.
    assign idle     = (state == IDLE);
    assign start    = idle && mio_en;
    assign complete = (state == REQ) && mem_ready;

`ifdef MEM_TIMEOUT_EN
    // Counter only has to hold 0 .. TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;

    // Abort on the REQ cycle that would make the wait count reach TIMEOUT;
    // mem_ready on that same edge takes priority.
    assign abort = (state == REQ) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Wait counter: cleared on each accepted start, counts REQ cycles without mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= '0;
        end else if ((state == REQ) && !mem_ready && !abort) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared when the next access is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (abort) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so no branch leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (mio_en) state_nxt = REQ;
            REQ:     if (mem_ready || abort) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // MAR: loads from the bus only while idle; a load with mio_en feeds that access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
        end else if (idle && ld_mar) begin
            mar <= bus_in[ADDR_W-1:0];
        end
    end

    // MDR: bus load while idle, read data on completion, all ones on an aborted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr <= '0;
        end else if (idle && ld_mdr) begin
            mdr <= bus_in;
        end else if (complete && !we_q) begin
            mdr <= mem_rdata;
        end else if (abort && !we_q) begin
            mdr <= '1;
        end
    end

    // Access type captured together with the start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q <= 1'b0;
        end else if (start) begin
            we_q <= r_w;
        end
    end

    // Handshake and status outputs decode straight from registered state.
    assign busy      = !idle;
    assign r_done    = (state == DONE);
    assign mem_req   = (state == REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: reset values, a table of directed
// transactions, busy lockout, asynchronous reset mid-access, randomized
// accesses against a transaction-level model, and (with MEM_TIMEOUT_EN)
// the timeout abort path with TIMEOUT = 8.
module tb_mem_access_ctrl;

    localparam int TB_TIMEOUT = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        busy;
    logic        r_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    mem_access_ctrl #(
        .ADDR_W (16),
        .DATA_W (16),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_in   (bus_in),
        .ld_mar   (ld_mar),
        .ld_mdr   (ld_mdr),
        .mio_en   (mio_en),
        .r_w      (r_w),
        .mar      (mar),
        .mdr      (mdr),
        .busy     (busy),
        .r_done   (r_done),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are driven and outputs sampled 2 time units after the rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // ---------------- memory responder ----------------
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } obs_t;

    logic [15:0] mem_array [logic [15:0]];
    obs_t        obs_q[$];
    int          wait_target = 0;   // REQ cycles to stall before ready; -1 = never
    logic        noise = 1'b0;      // drive mem_ready/garbage while no request
    int          wait_cnt_r = 0;
    int          done_cnt = 0;

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_array.exists(a)) return mem_array[a];
        return ~a;
    endfunction

    // Responder acts on the falling edge so its outputs are settled for the next rise.
    always @(negedge clk) begin
        if (r_done) done_cnt++;
        if (mem_req) begin
            if (wait_target >= 0 && wait_cnt_r == wait_target) begin
                mem_ready = 1'b1;
                mem_rdata = mem_we ? 16'h0000 : mem_read(mem_addr);
                if (mem_we) mem_array[mem_addr] = mem_wdata;
                obs_q.push_back('{mem_we, mem_addr, mem_wdata});
                wait_cnt_r = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
                wait_cnt_r++;
            end
        end else begin
            wait_cnt_r = 0;
            mem_ready  = noise;
            mem_rdata  = noise ? 16'hDEAD : 16'h0000;
        end
    end

    // ---------------- transaction driver ----------------
    // Loads MAR (unless same-cycle), loads MDR for writes, pulses mio_en and
    // follows the access until the controller is idle again.
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] data,
                           input int waits, input logic same, input logic poke,
                           output int req_cycles, output int done_cycles);
        int   n_obs;
        logic finished;
        n_obs = obs_q.size();
        if (!same) begin
            ld_mar = 1'b1; bus_in = addr; tick; ld_mar = 1'b0;
        end
        if (we) begin
            ld_mdr = 1'b1; bus_in = data; tick; ld_mdr = 1'b0;
        end
        wait_target = waits;
        mio_en = 1'b1;
        r_w    = we;
        if (same) begin
            ld_mar = 1'b1; bus_in = addr;
        end
        tick;
        mio_en = 1'b0; ld_mar = 1'b0; r_w = 1'b0;
        check("req_after_start", mem_req, 1);
        req_cycles  = 0;
        done_cycles = 0;
        finished    = 1'b0;
        for (int c = 0; c < 200 && !finished; c++) begin
            ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
            if (mem_req) begin
                req_cycles++;
                check("mem_addr", mem_addr, addr);
                check("mem_we", mem_we, we);
                if (we) check("mem_wdata", mem_wdata, data);
            end
            if (r_done) done_cycles++;
            if (!busy) begin
                finished = 1'b1;
            end else begin
                if (poke && c == 0) begin
                    ld_mar = 1'b1; ld_mdr = 1'b1; mio_en = 1'b1; r_w = ~we; bus_in = 16'h5555;
                end
                tick;
            end
        end
        ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
        check("txn_finished", finished, 1);
        check("mar_after_txn", mar, addr);
        if (waits >= 0) begin
            check("obs_count", obs_q.size(), n_obs + 1);
            if (obs_q.size() == n_obs + 1) begin
                check("obs_we", obs_q[n_obs].we, we);
                check("obs_addr", obs_q[n_obs].addr, addr);
                if (we) check("obs_wdata", obs_q[n_obs].wdata, data);
            end
        end else begin
            check("obs_count_abort", obs_q.size(), n_obs);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        int          waits;
        logic        same;
        logic        noise;
        logic [15:0] exp_mdr;
        int          exp_req;
    } vec_t;

    vec_t vecs[6];

    // ---------------- reference model for random phase ----------------
    logic [15:0] mar_m;
    logic [15:0] mdr_m;
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] addr_pool[8];

    int          rc;
    int          dc;
    int          dsnap;
    int          nsnap;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus_in = '0; ld_mar = 1'b0; ld_mdr = 1'b0;
        mio_en = 1'b0; r_w = 1'b0; mem_ready = 1'b0; mem_rdata = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #2;
        check("rst_mar", mar, 0);
        check("rst_mdr", mdr, 0);
        check("rst_busy", busy, 0);
        check("rst_r_done", r_done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick;

        // Directed transactions.
        mem_array[16'h0010] = 16'h1234;
        mem_array[16'h00FF] = 16'h0F0F;
        vecs[0] = '{1'b1, 16'h3000, 16'hABCD, 0, 1'b0, 1'b0, 16'hABCD, 1};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 3, 1'b0, 1'b0, 16'h1234, 4};
        vecs[2] = '{1'b0, 16'h00FF, 16'h0000, 0, 1'b1, 1'b1, 16'h0F0F, 1};
        vecs[3] = '{1'b0, 16'h3000, 16'h0000, 2, 1'b0, 1'b1, 16'hABCD, 3};
        vecs[4] = '{1'b1, 16'h00FF, 16'h8001, 5, 1'b1, 1'b0, 16'h8001, 6};
        vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 1, 1'b0, 1'b1, 16'h8001, 2};
        for (int i = 0; i < 6; i++) begin
            noise = vecs[i].noise;
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].waits,
                    vecs[i].same, 1'b0, rc, dc);
            check($sformatf("vec%0d_req_cycles", i), rc, vecs[i].exp_req);
            check($sformatf("vec%0d_r_done_width", i), dc, 1);
            check($sformatf("vec%0d_mdr", i), mdr, vecs[i].exp_mdr);
            check($sformatf("vec%0d_err", i), err, 0);
            repeat (2) tick;
            check($sformatf("vec%0d_mdr_idle", i), mdr, vecs[i].exp_mdr);
        end
        noise = 1'b0;

        // Busy lockout: ld_mdr 16'h5555, ld_mar and a second mio_en while in REQ.
        dsnap = done_cnt;
        nsnap = obs_q.size();
        run_txn(1'b1, 16'h0040, 16'h7777, 3, 1'b0, 1'b1, rc, dc);
        check("lock_req_cycles", rc, 4);
        check("lock_r_done_width", dc, 1);
        check("lock_mdr", mdr, 16'h7777);
        repeat (4) tick;
        check("lock_not_queued_busy", busy, 0);
        check("lock_one_txn", obs_q.size(), nsnap + 1);
        check("lock_one_done", done_cnt, dsnap + 1);
        check("lock_mar", mar, 16'h0040);

        // Asynchronous reset in the middle of an access.
        wait_target = -1;
        ld_mar = 1'b1; bus_in = 16'h0123; tick; ld_mar = 1'b0;
        mio_en = 1'b1; r_w = 1'b0; tick; mio_en = 1'b0;
        tick;
        check("rst_mid_in_req", mem_req, 1);
        dsnap = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mar", mar, 0);
        check("rst_mid_mdr", mdr, 0);
        repeat (2) tick;
        rst_n = 1'b1;
        repeat (4) tick;
        check("rst_mid_no_r_done", done_cnt, dsnap);
        check("rst_mid_idle", busy, 0);

        // Randomized accesses against the transaction-level model.
        mar_m = 16'h0000;
        mdr_m = 16'h0000;
        for (int i = 0; i < 8; i++) addr_pool[i] = 16'h8000 + 16'(i * 16'h0111);
        for (int it = 0; it < 40; it++) begin
            int          op;
            logic [15:0] a;
            logic [15:0] d;
            logic        lm;
            logic        ld;
            op = int'($urandom_range(0, 3));
            a  = addr_pool[$urandom_range(0, 7)];
            d  = 16'($urandom);
            if (op == 0) begin
                lm = 1'($urandom_range(0, 1));
                ld = 1'($urandom_range(0, 1));
                ld_mar = lm; ld_mdr = ld; bus_in = d;
                tick;
                ld_mar = 1'b0; ld_mdr = 1'b0;
                if (lm) mar_m = d;
                if (ld) mdr_m = d;
                check("rnd_load_mar", mar, mar_m);
                check("rnd_load_mdr", mdr, mdr_m);
            end else begin
                logic we;
                int   w;
                we    = (op == 1);
                w     = int'($urandom_range(0, 4));
                noise = 1'($urandom_range(0, 1));
                run_txn(we, a, d, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rc, dc);
                mar_m = a;
                if (we) begin
                    mdr_m      = d;
                    ref_mem[a] = d;
                end else begin
                    mdr_m = ref_mem.exists(a) ? ref_mem[a] : ~a;
                end
                check("rnd_req_cycles", rc, w + 1);
                check("rnd_r_done_width", dc, 1);
                check("rnd_mdr", mdr, mdr_m);
                check("rnd_mar", mar, mar_m);
                check("rnd_err", err, 0);
            end
        end
        noise = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Read with mem_ready held low: abort after TIMEOUT REQ cycles.
        run_txn(1'b0, 16'h0200, 16'h0000, -1, 1'b0, 1'b0, rc, dc);
        check("to_req_cycles", rc, TB_TIMEOUT);
        check("to_r_done_width", dc, 1);
        check("to_mdr", mdr, 16'hFFFF);
        check("to_err", err, 1);
        repeat (3) tick;
        check("to_err_sticky", err, 1);
        // mem_ready on the timeout edge wins; the accepted start also clears err.
        run_txn(1'b0, 16'h0300, 16'h0000, TB_TIMEOUT - 1, 1'b0, 1'b0, rc, dc);
        check("to_race_req_cycles", rc, TB_TIMEOUT);
        check("to_race_mdr", mdr, 16'hFCFF);
        check("to_race_err", err, 0);
`else
        check("err_tied_low", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

CPU-side memory access controller for the MCU datapath. Owns the MAR and MDR registers, loads them from the processor bus, and runs read and write transactions against the memory block through a request/ready handshake with arbitrary wait states. Signals completion to the control FSM with a one-cycle `r_done` pulse, the LC-3 "R" signal. Sits between the datapath bus and the memory array as the initiator side of the memory interface.

## Interface
Parameters:
- `ADDR_W`, 16: MAR / memory address width.
- `DATA_W`, 16: MDR / memory data width.
- `TIMEOUT`, 255: maximum wait cycles in REQ. Used only when `MEM_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bus_in`  in  DATA_W  processor bus value.
- `ld_mar`  in  1  load MAR from `bus_in[ADDR_W-1:0]`.
- `ld_mdr`  in  1  load MDR from `bus_in`.
- `mio_en`  in  1  start a memory access; single-cycle pulse.
- `r_w`  in  1  access type, sampled with `mio_en`: 1 = write, 0 = read.
- `mar`  out  ADDR_W  MAR contents.
- `mdr`  out  DATA_W  MDR contents; the datapath gates this onto the bus.
- `busy`  out  1  high in REQ and DONE.
- `r_done`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable, valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W  memory address, equal to `mar`.
- `mem_wdata`  out  DATA_W  write data, equal to `mdr`.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion, sampled only in REQ.
- `err`  out  1  sticky timeout flag.

## Operation
- The FSM has three states: IDLE, REQ, DONE.
- **IDLE:**
  - `ld_mar` loads MAR and `ld_mdr` loads MDR. Both may load in the same cycle.
  - When `mio_en` is high, capture `r_w` into `we_q` and go to REQ.
  - If `ld_mar` or `ld_mdr` is high in the same cycle as `mio_en`, the new MAR/MDR value is the one used by the access.
- **REQ:**
  - `mem_req` = 1 and `mem_we` = `we_q`.
  - Hold the state until `mem_ready` is sampled high.
  - On a read, MDR <= `mem_rdata` on that edge. On a write, MDR is unchanged.
  - Then go to DONE.
- **DONE:**
  - `mem_req` = 0 and `r_done` = 1 for exactly one cycle.
  - Then go to IDLE.
- While `busy` is high, `ld_mar`, `ld_mdr` and `mio_en` are ignored; a dropped `mio_en` is not queued.
- `mem_ready` outside REQ is ignored.
- `mem_req`, `mem_we` and `r_done` are decoded from registered state, so they are glitch-free.

## Timing
- Reset values:
  - state IDLE; `mar` 0; `mdr` 0; `we_q` 0.
  - `busy`, `r_done`, `mem_req`, `mem_we`, `err` all 0.
- Reset is asynchronous: asserting `rst_n` mid-access drops `mem_req` immediately and abandons the access. No `r_done` is produced.
- `mio_en` sampled at edge N gives `mem_req` high after edge N.
- With `mem_ready` high in the first REQ cycle:
  - MDR updates at edge N+1.
  - `r_done` is high between edges N+1 and N+2.
  - The FSM is back in IDLE after edge N+2.
  - Minimum start-to-start spacing is 3 cycles.
- Each cycle `mem_ready` stays low adds one REQ cycle.
- `mem_addr` and `mem_wdata` are stable for the whole time `mem_req` is high.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to REQ and increments on each REQ cycle without `mem_ready`.
  - When the counter reaches `TIMEOUT`, the access aborts: go to DONE, `r_done` pulses, `err` <= 1.
  - On an aborted read, MDR <= all ones.
  - `err` clears when the next `mio_en` is accepted.
  - If `mem_ready` and the timeout occur on the same edge, `mem_ready` wins: normal completion, no error.
- `MEM_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `err` is tied to 0, and no counter logic is generated.

## Test plan
- Write with zero wait states: `ld_mar` with bus 16'h3000, then `ld_mdr` with bus 16'hABCD, then `mio_en`/`r_w`=1.
  - `mem_req`/`mem_we` high for 1 cycle with `mem_addr`=16'h3000 and `mem_wdata`=16'hABCD.
  - `r_done` pulses on the following cycle.
- Read with 3 wait states: MAR=16'h0010, `mem_rdata`=16'h1234, `mem_ready` asserted on the 4th REQ cycle.
  - `mdr`=16'h1234 and `r_done` is exactly one cycle wide.
- Same-cycle load and start: `ld_mar` (bus 16'h00FF) and `mio_en` in the same cycle → `mem_addr`=16'h00FF on the first `mem_req` cycle.
- Busy lockout: `ld_mdr` (bus 16'h5555) and a second `mio_en` pulse while in REQ → MDR unchanged and only one transaction occurs.
- Reset mid-access: `rst_n` low while in REQ → `mem_req`, `busy`, `mar`, `mdr` are 0 immediately and `r_done` never pulses.
- With `MEM_TIMEOUT_EN` and `TIMEOUT`=8: read with `mem_ready` held low.
  - After 8 REQ cycles `r_done` pulses, `mdr`=16'hFFFF and `err`=1.
  - The next accepted `mio_en` clears `err`.
